// File: rtl/mux_4to1_pkg.sv
// Shared select encoding and default data width for the 4:1 registered selector.
package mux_4to1_pkg;

  localparam int MUX_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_t;

endpackage

// File: rtl/mux_4to1_2bit_enable_if.sv
// Bus bundle for the 4:1 selector: four data inputs, select, enable, registered result.
interface mux_4to1_2bit_enable_if
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  sel_t             sel;
  logic             enable;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output a, b, c, d, sel, enable,
    input  out, out_valid
  );

  modport slave (
    input  a, b, c, d, sel, enable,
    output out, out_valid
  );

endinterface

// File: rtl/mux_4to1_core.sv
// Purely combinational WIDTH-bit 4:1 select; unknown select codes resolve to zero.
module mux_4to1_core
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  sel_t             sel_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      SEL_A:   y_o = a_i;
      SEL_B:   y_o = b_i;
      SEL_C:   y_o = c_i;
      SEL_D:   y_o = d_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/mux_4to1_2bit_enable.sv
// Registered 4:1 selector with enable gating; one-cycle latency, no input-to-output path.
// Optional MUX_HOLD_ON_DISABLE_EN: out keeps its last value while enable is low.
module mux_4to1_2bit_enable
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_4to1_2bit_enable_if.slave bus
);

  logic [WIDTH-1:0] sel_y;
  logic [WIDTH-1:0] out_d, out_q;
  logic             vld_d, vld_q;

  mux_4to1_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .c_i   (bus.c),
    .d_i   (bus.d),
    .sel_i (bus.sel),
    .y_o   (sel_y)
  );

  always_comb begin
    vld_d = bus.enable;
`ifdef MUX_HOLD_ON_DISABLE_EN
    out_d = bus.enable ? sel_y : out_q;
`else
    out_d = bus.enable ? sel_y : '0;
`endif
  end

  // Reset clears both registers regardless of the hold option.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_mux_4to1_2bit_enable.sv
// Scoreboard bench for mux_4to1_2bit_enable: directed plan followed by a random run.
module tb_mux_4to1_2bit_enable;
  import mux_4to1_pkg::*;

  localparam int W = 2;

  typedef struct packed {
    logic         v;
    logic [W-1:0] o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din [4];
  logic [1:0]   sel_v = 2'b00;
  logic         en_v = 1'b0;
  logic [W-1:0] hold_q = '0;
  exp_t         sb [$];
  int           n_tests = 0;
  int           n_fail = 0;

  mux_4to1_2bit_enable_if #(.WIDTH(W)) bus ();

  assign bus.a      = din[0];
  assign bus.b      = din[1];
  assign bus.c      = din[2];
  assign bus.d      = din[3];
  assign bus.sel    = sel_t'(sel_v);
  assign bus.enable = en_v;

  mux_4to1_2bit_enable #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: index the input array directly rather than decoding sel.
  function automatic exp_t model();
    exp_t e;
    e.v = en_v;
    if (en_v) e.o = din[sel_v];
`ifdef MUX_HOLD_ON_DISABLE_EN
    else e.o = hold_q;
`else
    else e.o = '0;
`endif
    return e;
  endfunction

  task automatic step(input string tag);
    exp_t e;
    e = model();
    if (en_v) hold_q = e.o;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val({tag, "_out"}, 8'(bus.out), 8'(e.o));
    check_val({tag, "_vld"}, 8'(bus.out_valid), 8'(e.v));
  endtask

  initial begin
    din[0] = 2'b00; din[1] = 2'b01; din[2] = 2'b10; din[3] = 2'b11;
    en_v = 1'b1; sel_v = 2'b11;
    #1;
    check_val("rst_async_out", 8'(bus.out), 8'h0);
    check_val("rst_async_vld", 8'(bus.out_valid), 8'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_out", 8'(bus.out), 8'h0);
    check_val("rst_hold_vld", 8'(bus.out_valid), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release");

    for (int i = 0; i < 4; i++) begin
      sel_v = 2'(i);
      step($sformatf("sweep%0d", i));
    end

    en_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_v = 2'(i);
      step($sformatf("dis%0d", i));
    end

    en_v = 1'b1; sel_v = 2'b00;
    step("reen_a");
    sel_v = 2'b10;
    step("reen_c");

    // Data change between edges must not reach out before the next edge.
    din[2] = 2'b01;
    #2;
    check_val("lat_before", 8'(bus.out), 8'h2);
    step("lat_after");

    din[2] = 2'b10;
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out", 8'(bus.out), 8'h0);
    check_val("midrst_vld", 8'(bus.out_valid), 8'h0);
    hold_q = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sel_v = 2'b01;
    step("post_rst");

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) din[k] = 2'($urandom_range(3));
      sel_v = 2'($urandom_range(3));
      en_v  = ($urandom_range(3) != 0);
      step($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
